// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment driver: per-digit dwell with anode dead time,
// hex decode, decimal point, blanking and frame-synchronous blinking.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int DEADTIME     = 2000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEADTIME);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [FRM_W-1:0]      frame_cnt;
  logic                  blink_phase;

  logic                  slot_end;
  logic                  frame_end;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] an_next;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_end  = enable && (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Walk the digits rather than slicing by idx so non-power-of-two digit
  // counts never index past the input vectors.
  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    an_next   = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_digit = digits[4*k +: 4];
        cur_dp    = dp_in[k];
        if (enable && (cnt >= CNT_DEAD) && !blank_mask[k] &&
            !(blink_mask[k] && blink_phase))
          an_next[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      if (enable) begin
        if (slot_end) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      // Toggle lands on the same edge as the idx wrap, so the new phase
      // already applies to the first slot of the next frame.
      if (frame_end) begin
        if (frame_cnt == FRM_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end
      an         <= an_next;
      seg        <= hex7(cur_digit);
      dp         <= ~cur_dp;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised, time-multiplexed 7-segment display driver that replaces the free-running 4-digit anode rotation in the stopwatch top level.
- Holds a programmable dwell time per digit and blanks all anodes for a short dead time at each digit change, to prevent ghosting.
- Provides per-digit hex decode, decimal point, blanking and blinking; the blink feature is used to flag the digit being adjusted.
- Sits between the counter/BCD logic and the board pins.

Parameters:
- NUM_DIGITS, 4, number of digits and anodes (1..16).
- SCAN_DIV, 100000, clk cycles per digit slot (>=2).
- DEADTIME, 2000, cycles at the start of each slot with all anodes off (0 <= DEADTIME < SCAN_DIV).
- BLINK_FRAMES, 128, full scan frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = scanning runs; 0 = counters hold and all anodes are off.
- digits  in  4*NUM_DIGITS  hex value per digit; digit k is digits[4k+3:4k]; digit 0 is the rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit (1 = lit).
- blank_mask  in  NUM_DIGITS  1 = digit k is never lit.
- blink_mask  in  NUM_DIGITS  1 = digit k is dark during the blink-off phase.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- an  out  NUM_DIGITS  active-low anodes; an[k] drives digit k.
- frame_tick  out  1  one-cycle pulse per completed scan frame.

Behaviour:
- Single clock domain. Reset is synchronous and active-high and has priority over all other inputs.
- Reset values:
  - slot counter cnt = 0, digit index idx = 0, frame counter = 0, blink_phase = 0 (visible).
  - an = all 1s, seg = 7'h7F, dp = 1, frame_tick = 0.
- Prescaler (when enable = 1):
  - cnt increments each cycle.
  - At cnt == SCAN_DIV-1: cnt <= 0 and idx advances (idx <= idx+1, or wraps to 0 from NUM_DIGITS-1).
  - idx width is max(1, clog2(NUM_DIGITS)).
- Frame and blink:
  - The wrap of idx ends a frame. On that edge the frame counter increments.
  - When the frame counter reaches BLINK_FRAMES-1 it clears to 0 and blink_phase toggles.
- Outputs are fully registered, with one cycle of latency from the internal state (cnt, idx, blink_phase) and from the inputs.
  - Digit inputs are sampled live each cycle; no frame-level latching.
- Anode selection: an[k] = 0 only when all of the following hold:
  - k == idx
  - enable == 1
  - cnt >= DEADTIME
  - blank_mask[k] == 0
  - not (blink_mask[k] == 1 and blink_phase == 1)
  - All other anodes are 1.
- seg and dp always reflect digit idx, even while its anode is off:
  - seg = decode(digits[idx]); dp = ~dp_in[idx].
- frame_tick is 1 for exactly the one cycle following the idx-wrap edge.
- Hex decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- enable = 0:
  - cnt, idx, frame counter and blink_phase hold.
  - an = all 1s from the next cycle.
  - On re-enable, scanning resumes from the held cnt and idx.
- Reset asserted mid-slot: on the next edge all state returns to reset values. The first slot after reset is digit 0, starting with its dead time.
- NUM_DIGITS = 1: idx stays 0. Each slot end is a frame end, so frame_tick pulses every SCAN_DIV cycles.
- Simultaneous events: a blink toggle and an idx wrap on the same edge are both applied. The new blink_phase governs the first slot of the new frame.

Test Plan:
- Scan sequence (NUM_DIGITS=4, SCAN_DIV=4, DEADTIME=1, digits=16'h1234, masks 0, enable=1 after reset) -> an cycles through:
  - 1111,1110,1110,1110
  - 1111,1101,1101,1101
  - 1111,1011,1011,1011
  - 1111,0111,0111,0111
  - seg shows 1111001 during slot 0, 0100100 slot 1, 0110000 slot 2, 0011001 slot 3.
  - frame_tick pulses every 16 cycles.
- Blink (BLINK_FRAMES=2, blink_mask=4'b0100) -> an[2] is low for 2 frames, then high for the whole of slot 2 for 2 frames, repeating. Other digits are unaffected.
- Blank and dp (blank_mask=4'b1000, dp_in=4'b0100) -> an[3] is never 0; dp = 0 only during slot 2.
- Decode sweep (digits[3:0] stepped 0..F, one value per frame) -> seg matches the table for all 16 values.
- Enable and reset:
  - Drop enable mid-slot 2 -> an = 1111 next cycle, idx and cnt frozen; re-enable resumes slot 2 with the remaining cycles.
  - Assert reset mid-slot 3 -> next cycle an = 1111, seg = 7F, dp = 1, frame_tick = 0; after release, scanning restarts at slot 0.
- Single digit (NUM_DIGITS=1, SCAN_DIV=4, DEADTIME=1) -> an pattern is 1,0,0,0 repeating; frame_tick every 4 cycles.
